// File: rtl/fsm_state_monitor.sv
// fsm_state_monitor: consuming-end checker for the 3-bit FSM state-code stream.
// It tracks the producer's cyclic ST0..ST7 sequence, where a state may be held.
// A free-running bunch-crossing counter stamps every reported error.
// The optional saturating error counter (err_cnt_o) is built only when the
// macro FSM_MON_ERR_CNT_EN is defined.

package my_package_pkg;
    localparam int unsigned LSB_CNT_MAX = 3564;

    typedef enum logic [2:0] {
        FSM_ST0 = 3'd0,
        FSM_ST1 = 3'd1,
        FSM_ST2 = 3'd2,
        FSM_ST3 = 3'd3,
        FSM_ST4 = 3'd4,
        FSM_ST5 = 3'd5,
        FSM_ST6 = 3'd6,
        FSM_ST7 = 3'd7
    } FSM_States_t;
endpackage

module fsm_state_monitor #(
    parameter int unsigned CNT_MAX   = my_package_pkg::LSB_CNT_MAX,
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 state_vld_i,
    input  logic [2:0]           state_i,
    input  logic                 orbit_sync_i,
    output logic [CNT_W-1:0]     bc_cnt_o,
    output logic                 orbit_o,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     err_bc_o,
    output logic [2:0]           err_state_o
`ifdef FSM_MON_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTrack  = 2'd1,
        StResync = 2'd2
    } mon_state_e;

    // Last BC of the orbit; also the last legal stall count before a stall error.
    localparam logic [CNT_W-1:0] BcLast    = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] StallLast = CNT_W'(CNT_MAX - 1);

    mon_state_e       r_state;
    mon_state_e       w_state_nxt;
    logic [2:0]       r_last;
    logic [2:0]       w_last_nxt;
    logic [2:0]       w_succ;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] w_stall_nxt;
    logic [CNT_W-1:0] r_bc;
    logic [CNT_W-1:0] w_bc_nxt;
    logic             w_err;
    logic [2:0]       w_err_state;

    logic             r_orbit;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_err_bc;
    logic [2:0]       r_err_state;

    assign w_succ = r_last + 3'd1;  // 3-bit wrap makes ST7 -> ST0 legal

    // BC counter next value: sync beats wrap beats increment.
    always_comb begin
        w_bc_nxt = r_bc + CNT_W'(1);
        if (r_bc == BcLast) begin
            w_bc_nxt = '0;
        end
        if (orbit_sync_i) begin
            w_bc_nxt = '0;
        end
    end

    // Monitor next-state, last-state tracking, stall counting and error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_stall_nxt = r_stall;
        w_err       = 1'b0;
        w_err_state = state_i;
        unique case (r_state)
            StIdle, StResync: begin
                // Wait quietly for ST0 to (re)acquire the sequence.
                if (state_vld_i && (state_i == my_package_pkg::FSM_ST0)) begin
                    w_state_nxt = StTrack;
                    w_last_nxt  = my_package_pkg::FSM_ST0;
                    w_stall_nxt = '0;
                end
            end
            StTrack: begin
                if (state_vld_i) begin
                    if (state_i == r_last) begin
                        if (r_stall == StallLast) begin
                            w_err       = 1'b1;
                            w_err_state = r_last;
                            w_state_nxt = StResync;
                            w_stall_nxt = '0;
                        end else begin
                            w_stall_nxt = r_stall + CNT_W'(1);
                        end
                    end else if (state_i == w_succ) begin
                        w_last_nxt  = state_i;
                        w_stall_nxt = '0;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = StResync;
                        w_stall_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Monitor state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_last  <= my_package_pkg::FSM_ST0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    // Registered outputs; err stamp uses the BC value seen alongside the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bc        <= '0;
            r_orbit     <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_bc    <= '0;
            r_err_state <= '0;
        end else begin
            r_bc     <= w_bc_nxt;
            r_orbit  <= (w_bc_nxt == BcLast);
            r_locked <= (r_state == StTrack);
            r_err    <= w_err;
            if (w_err) begin
                r_err_bc    <= r_bc;
                r_err_state <= w_err_state;
            end
        end
    end

    assign bc_cnt_o    = r_bc;
    assign orbit_o     = r_orbit;
    assign locked_o    = r_locked;
    assign err_o       = r_err;
    assign err_bc_o    = r_err_bc;
    assign err_state_o = r_err_state;

`ifdef FSM_MON_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] ErrCntMax = '1;

    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating error count, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != ErrCntMax)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_err_cnt_w;
    assign w_unused_err_cnt_w = (ERR_CNT_W != 0);
`endif

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Testbench for fsm_state_monitor: directed scenarios plus a randomized run,
// all checked against a sequence-level reference model.
// Build with FSM_MON_ERR_CNT_EN to also exercise the 2-bit error counter.

module tb_fsm_state_monitor;

    localparam int unsigned CNT_MAX = 3564;
    localparam int unsigned CNT_W   = 12;
`ifdef FSM_MON_ERR_CNT_EN
    localparam int unsigned ERR_CNT_W = 2;
`else
    localparam int unsigned ERR_CNT_W = 8;
`endif
    localparam int ErrCntSat = (1 << ERR_CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             state_vld_i = 1'b0;
    logic [2:0]       state_i = 3'd0;
    logic             orbit_sync_i = 1'b0;
    logic [CNT_W-1:0] bc_cnt_o;
    logic             orbit_o;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_bc_o;
    logic [2:0]       err_state_o;
`ifdef FSM_MON_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_o;
`endif

    fsm_state_monitor #(
        .CNT_MAX  (CNT_MAX),
        .CNT_W    (CNT_W),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state_vld_i (state_vld_i),
        .state_i     (state_i),
        .orbit_sync_i(orbit_sync_i),
        .bc_cnt_o    (bc_cnt_o),
        .orbit_o     (orbit_o),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .err_bc_o    (err_bc_o),
`ifdef FSM_MON_ERR_CNT_EN
        .err_state_o (err_state_o),
        .err_cnt_o   (err_cnt_o)
`else
        .err_state_o (err_state_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sequence-level view of the producer stream.
    int m_bc, m_last, m_holds, m_err_bc, m_err_state, m_cnt;
    bit m_tracking, m_locked, m_err, m_orbit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bc = 0; m_last = 0; m_holds = 0; m_err_bc = 0; m_err_state = 0; m_cnt = 0;
        m_tracking = 0; m_locked = 0; m_err = 0; m_orbit = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bc"},        32'(bc_cnt_o),    32'(m_bc));
        check({tag, ".orbit"},     32'(orbit_o),     32'(m_orbit));
        check({tag, ".locked"},    32'(locked_o),    32'(m_locked));
        check({tag, ".err"},       32'(err_o),       32'(m_err));
        check({tag, ".err_bc"},    32'(err_bc_o),    32'(m_err_bc));
        check({tag, ".err_state"}, 32'(err_state_o), 32'(m_err_state));
`ifdef FSM_MON_ERR_CNT_EN
        check({tag, ".err_cnt"},   32'(err_cnt_o),   32'(m_cnt));
`endif
    endtask

    task automatic model_error(input int code);
        m_err = 1;
        m_err_bc = m_bc;
        m_err_state = code;
        m_tracking = 0;
        m_holds = 0;
        if (m_cnt < ErrCntSat) m_cnt++;
    endtask

    // Apply one cycle of stimulus, advance the model, check after the edge.
    task automatic step(input string tag, input bit v, input int s, input bit sy);
        state_vld_i = v;
        state_i = 3'(s);
        orbit_sync_i = sy;
        m_locked = m_tracking;
        m_err = 0;
        if (v) begin
            if (!m_tracking) begin
                if (s == 0) begin
                    m_tracking = 1; m_last = 0; m_holds = 0;
                end
            end else if (s == m_last) begin
                m_holds++;
                if (m_holds == CNT_MAX) model_error(m_last);
            end else if (s == (m_last + 1) % 8) begin
                m_last = s; m_holds = 0;
            end else begin
                model_error(s);
            end
        end
        m_bc = sy ? 0 : (m_bc + 1) % CNT_MAX;
        m_orbit = (m_bc == CNT_MAX - 1);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int n;
        int exp_bc;
        int r, s;
        bit v, sy;
        int exp_cnt [5];
        exp_cnt = '{1, 2, 3, 3, 3};

        model_reset();
        #3;
        check_all("reset");
        #9 rst_n = 1'b1;

        // Legal full cycle; never an error.
        n = 0;
        for (int i = 0; i < 9; i++) begin
            step("seq", 1'b1, i % 8, 1'b0);
            if (err_o) n++;
        end
        check("seq_no_err", 32'(n), 32'd0);
        check("seq_locked", 32'(locked_o), 32'd1);

        // Illegal jump ST2 -> ST5 at bc 100.
        step("lock2", 1'b1, 1, 1'b0);
        step("lock2", 1'b1, 2, 1'b0);
        while (m_bc != 100) step("to100", 1'b0, 0, 1'b0);
        step("jump", 1'b1, 5, 1'b0);
        check("jump_err", 32'(err_o), 32'd1);
        check("jump_bc", 32'(err_bc_o), 32'd100);
        check("jump_state", 32'(err_state_o), 32'd5);
        step("after_jump", 1'b0, 0, 1'b0);
        check("jump_unlock", 32'(locked_o), 32'd0);
        step("relock", 1'b1, 0, 1'b0);
        step("relock", 1'b1, 1, 1'b0);
        step("relock", 1'b1, 1, 1'b0);
        check("relocked", 32'(locked_o), 32'd1);

        // Full orbit free run, then orbit sync at bc 1000.
        n = 0;
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            step("orbit", 1'b0, 0, 1'b0);
            if (orbit_o) n++;
        end
        check("orbit_once", 32'(n), 32'd1);
        while (m_bc != 1000) step("to1000", 1'b0, 0, 1'b0);
        step("sync", 1'b0, 0, 1'b1);
        check("sync_bc", 32'(bc_cnt_o), 32'd0);

        // Stall at ST4 with consecutive valid holds.
        for (int i = 2; i <= 4; i++) step("lock4", 1'b1, i, 1'b0);
        for (int i = 0; i < int'(CNT_MAX); i++) step("stall", 1'b1, 4, 1'b0);
        check("stall_err", 32'(err_o), 32'd1);
        check("stall_state", 32'(err_state_o), 32'd4);

        // Same stall with invalid gaps interleaved.
        for (int i = 0; i <= 4; i++) step("relock4", 1'b1, i, 1'b0);
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            if ($urandom_range(0, 2) == 0) step("gap", 1'b0, int'($urandom_range(0, 7)), 1'b0);
            step("stall_gap", 1'b1, 4, 1'b0);
        end
        check("stall_gap_err", 32'(err_o), 32'd1);
        check("stall_gap_state", 32'(err_state_o), 32'd4);

        // Error on the wrapping sample stamps CNT_MAX-1.
        step("lockw", 1'b1, 0, 1'b0);
        while (m_bc != int'(CNT_MAX) - 1) step("towrap", 1'b0, 0, 1'b0);
        step("wrap_err", 1'b1, 6, 1'b0);
        check("wrap_bc", 32'(err_bc_o), 32'(CNT_MAX - 1));
        check("wrap_cnt", 32'(bc_cnt_o), 32'd0);

        // Error together with orbit sync stamps the pre-sync value.
        step("locks", 1'b1, 0, 1'b0);
        for (int i = 0; i < 37; i++) step("tosync", 1'b0, 0, 1'b0);
        exp_bc = m_bc;
        step("sync_err", 1'b1, 2, 1'b1);
        check("sync_err_bc", 32'(err_bc_o), 32'(exp_bc));
        check("sync_err_cnt", 32'(bc_cnt_o), 32'd0);

        // Asynchronous reset in the middle of TRACK.
        step("lockr", 1'b1, 0, 1'b0);
        step("lockr", 1'b1, 1, 1'b0);
        step("lockr", 1'b1, 2, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #7 rst_n = 1'b1;
        step("post_rst", 1'b1, 3, 1'b0);
        step("post_rst", 1'b1, 5, 1'b0);
        check("post_rst_noerr", 32'(err_o), 32'd0);

`ifdef FSM_MON_ERR_CNT_EN
        // Counter saturation with a 2-bit error counter.
        for (int i = 0; i < 5; i++) begin
            step("cnt_lock", 1'b1, 0, 1'b0);
            step("cnt_err", 1'b1, 5, 1'b0);
            check("err_cnt_seq", 32'(err_cnt_o), 32'(exp_cnt[i]));
        end
`endif

        // Randomized mix of progressions, holds, jumps, gaps and syncs.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 99));
            if (r < 60) s = (m_last + 1) % 8;
            else if (r < 80) s = m_last;
            else s = int'($urandom_range(0, 7));
            if (!m_tracking && r < 50) s = 0;
            sy = ($urandom_range(0, 199) == 0);
            step("rand", v, s, sy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_state_monitor.md
Name: fsm_state_monitor

Overview:
- Receiver/checker for the 3-bit FSM state-code stream defined by `my_package_pkg`. It is the consuming end of producers that drive `FSM_States_t` codes.
- Tracks the producer's state sequence against the legal cyclic order FSM_ST0→FSM_ST1→…→FSM_ST7→FSM_ST0, with hold allowed.
- Keeps a bunch-crossing (BC) counter that wraps at `LSB_CNT_MAX`. Each error it reports is stamped with the BC number.
- Sits beside any package-driven FSM as a TMR-testable sequential observer.

Parameters:
- CNT_MAX, default `my_package_pkg::LSB_CNT_MAX` (3564): BCs per orbit.
- CNT_W, default 12: BC counter width. Must satisfy 2**CNT_W >= CNT_MAX.
- ERR_CNT_W, default 8: error counter width. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- state_vld_i  in  1  state_i is valid this cycle
- state_i  in  3  producer state code (`FSM_States_t` encoding)
- orbit_sync_i  in  1  forces the BC counter to 0 on the next cycle
- bc_cnt_o  out  CNT_W  current BC number, 0..CNT_MAX-1
- orbit_o  out  1  one-cycle pulse in the cycle where bc_cnt_o == CNT_MAX-1
- locked_o  out  1  monitor is in TRACK
- err_o  out  1  one-cycle error pulse
- err_bc_o  out  CNT_W  bc_cnt_o value at the errored sample; held until the next error
- err_state_o  out  3  offending state_i; held until the next error
- err_cnt_o  out  ERR_CNT_W  saturating error count. Present only with `FSM_MON_ERR_CNT_EN`.

Behaviour:
- Reset (async, rst_n=0): every output is 0, monitor is in IDLE, last-state register is FSM_ST0, stall counter is 0. Outputs are registered and reset cleanly even mid-operation.
- BC counter:
  - Increments every cycle; value CNT_MAX-1 wraps to 0.
  - orbit_sync_i=1 loads 0 next cycle and takes priority over increment and wrap.
  - orbit_o = (bc_cnt_o == CNT_MAX-1), registered and aligned with bc_cnt_o.
- Monitor FSM states: IDLE, TRACK, RESYNC.
  - IDLE: a valid sample equal to FSM_ST0 → TRACK, last=ST0. Other valid samples are ignored; no error.
  - TRACK:
    - A valid sample equal to last → hold; stall counter +1.
    - A valid sample equal to (last+1) mod 8 → last=sample; stall counter cleared.
    - ST7→ST0 is legal.
    - Any other valid sample → err_o pulse, capture err_bc_o/err_state_o, go to RESYNC.
  - TRACK stall: when the stall counter reaches CNT_MAX consecutive valid holds → err_o pulse, err_state_o=last, go to RESYNC.
  - RESYNC: a valid FSM_ST0 → TRACK with counters cleared. No further errors are reported while in RESYNC.
  - Invalid cycles (state_vld_i=0) change nothing and do not advance the stall counter.
- Latency: err_o, err_bc_o and err_state_o assert 1 cycle after the offending sample.
  - err_bc_o holds the bc_cnt_o value seen in the same cycle as the sample.
  - locked_o reflects the FSM state, registered, 1 cycle after the transition.
- Simultaneous events:
  - An error on the sample where the BC counter wraps stamps CNT_MAX-1.
  - An error in the same cycle as orbit_sync_i stamps the pre-sync value.
- Arithmetic: next-state check is 3-bit modulo. Stall counter is CNT_W bits and cannot overflow, because it stops at CNT_MAX.

Optional Feature:
- Macro `FSM_MON_ERR_CNT_EN`.
- Defined:
  - err_cnt_o exists.
  - It increments on every err_o pulse and saturates at 2**ERR_CNT_W-1.
  - Only rst_n clears it.
- Undefined: port err_cnt_o and its register are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then valid ST0,ST1,…,ST7,ST0 one per cycle → locked_o=1 from cycle 2 on; err_o never asserts.
- Locked at ST2, then valid ST5 at bc 100 → err_o pulse next cycle, err_bc_o=100, err_state_o=3'b101, locked_o drops; a subsequent ST0 relocks.
- Free run of 3564 cycles → bc_cnt_o goes 3563→0, and orbit_o is high exactly at bc 3563 once per orbit. Asserting orbit_sync_i at bc 1000 → bc_cnt_o=0 the next cycle.
- Locked at ST4 with 3564 consecutive valid ST4 samples → stall err_o with err_state_o=3'b100. The same test with state_vld_i=0 gaps interleaved produces the error only after 3564 valid samples.
- rst_n asserted mid-TRACK (async, between clock edges) → all outputs 0 immediately and FSM returns to IDLE. A non-ST0 first sample after reset produces no error.
- With `FSM_MON_ERR_CNT_EN` and ERR_CNT_W=2: 5 injected errors → err_cnt_o reads 1,2,3,3,3.
